// File: rtl/bus_reg_bank_if.sv
// bus_reg_bank_if
//   Command and data-bus bundle for bus_reg_bank.
//   Parameters: WIDTH (bus/register width), ADDR_W (register address width).
//   Signals:
//     cmd_valid / cmd_ready  command handshake (master -> bank / bank -> master)
//     cmd_op [2:0]           operation code
//     cmd_addr, cmd_src      target and source register addresses
//     bus_in                 value consumed by LOAD
//     bus_out, bus_oe        registered bus drive value and its one-cycle enable
//   Modports: master (sequencer side), slave (register bank side).
interface bus_reg_bank_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_src;
  logic [WIDTH-1:0]  bus_in;
  logic [WIDTH-1:0]  bus_out;
  logic              bus_oe;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_src, bus_in,
    input  cmd_ready, bus_out, bus_oe
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_src, bus_in,
    output cmd_ready, bus_out, bus_oe
  );
endinterface

// File: rtl/bus_reg_bank.sv
// bus_reg_bank
//   Bank of DEPTH registers of WIDTH bits behind a valid/ready command port.
//   Operations: NOP, LOAD, OUT, INC, DEC, CLR, MOV (two-cycle register move).
//   Optional feature: define BANK_FLAGS_EN to build the zero/carry flags;
//   without it flag_zero and flag_carry are tied low.
//   Ports:
//     clk        clock, all state changes on the rising edge
//     rst        synchronous active-high reset
//     bus        bus_reg_bank_if.slave: command handshake, bus_in, bus_out/bus_oe
//     mon_addr   monitor read address
//     mon_value  combinational read of the addressed register (0 when out of range)
//     flag_zero  last written value was zero
//     flag_carry last INC wrapped or last DEC borrowed
module bus_reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  bus_reg_bank_if.slave     bus,
  input  logic [ADDR_W-1:0] mon_addr,
  output logic [WIDTH-1:0]  mon_value,
  output logic              flag_zero,
  output logic              flag_carry
);

  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_OUT  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_MOV  = 3'd6;

  // One extra bit so the range check also works when DEPTH is a power of two.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  typedef enum logic [1:0] {IDLE, MOV_RD, MOV_WR} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_regs [DEPTH];
  logic [ADDR_W-1:0] r_mov_dst;
  logic [ADDR_W-1:0] r_mov_src;
  logic [WIDTH-1:0]  r_temp;
  logic [WIDTH-1:0]  r_bus_out;
  logic              r_bus_oe;

  logic              w_accept;
  logic              w_addr_ok;
  logic              w_mov_ok;
  logic [WIDTH-1:0]  w_tgt_value;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [WIDTH-1:0]  w_wr_data;
  logic              w_out_fire;

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.bus_out   = r_bus_out;
  assign bus.bus_oe    = r_bus_oe;

  assign w_accept    = bus.cmd_valid && (r_state == IDLE);
  assign w_addr_ok   = in_range(bus.cmd_addr);
  assign w_mov_ok    = in_range(r_mov_dst) && in_range(r_mov_src);
  assign w_tgt_value = r_regs[bus.cmd_addr];

  // Monitor sees pre-edge contents; no bypass of a write happening this cycle.
  assign mon_value = in_range(mon_addr) ? r_regs[mon_addr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the single shared write port into the register array.
  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_wr_addr    = bus.cmd_addr;
    w_wr_data    = w_tgt_value;
    w_out_fire   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_LOAD: begin
              w_wr_en   = w_addr_ok;
              w_wr_data = bus.bus_in;
            end
            OP_OUT:  w_out_fire = w_addr_ok;
            OP_INC: begin
              w_wr_en   = w_addr_ok;
              w_wr_data = w_tgt_value + WIDTH'(1);
            end
            OP_DEC: begin
              w_wr_en   = w_addr_ok;
              w_wr_data = w_tgt_value - WIDTH'(1);
            end
            OP_CLR: begin
              w_wr_en   = w_addr_ok;
              w_wr_data = '0;
            end
            // Out-of-range MOV still walks both busy states; the write is suppressed.
            OP_MOV:  w_state_next = MOV_RD;
            default: ;
          endcase
        end
      end
      MOV_RD: w_state_next = MOV_WR;
      MOV_WR: begin
        w_state_next = IDLE;
        w_wr_en      = w_mov_ok;
        w_wr_addr    = r_mov_dst;
        w_wr_data    = r_temp;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mov_dst <= '0;
      r_mov_src <= '0;
      r_temp    <= '0;
      r_bus_out <= '0;
      r_bus_oe  <= 1'b0;
    end else begin
      r_bus_oe <= w_out_fire;
      if (w_out_fire) begin
        r_bus_out <= w_tgt_value;
      end
      if (w_accept && (bus.cmd_op == OP_MOV)) begin
        r_mov_dst <= bus.cmd_addr;
        r_mov_src <= bus.cmd_src;
      end
      if ((r_state == MOV_RD) && in_range(r_mov_src)) begin
        r_temp <= r_regs[r_mov_src];
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        r_regs[gi] <= '0;
      end else if (w_wr_en && (w_wr_addr == ADDR_W'(gi))) begin
        r_regs[gi] <= w_wr_data;
      end
    end
  end

`ifdef BANK_FLAGS_EN
  logic w_wr_carry;
  logic r_flag_zero;
  logic r_flag_carry;

  // Carry only comes from an INC of all-ones or a DEC of zero; every other write clears it.
  assign w_wr_carry = (r_state == IDLE) &&
                      (((bus.cmd_op == OP_INC) && (&w_tgt_value)) ||
                       ((bus.cmd_op == OP_DEC) && !(|w_tgt_value)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_zero  <= 1'b0;
      r_flag_carry <= 1'b0;
    end else if (w_wr_en) begin
      r_flag_zero  <= (w_wr_data == '0);
      r_flag_carry <= w_wr_carry;
    end
  end

  assign flag_zero  = r_flag_zero;
  assign flag_carry = r_flag_carry;
`else
  assign flag_zero  = 1'b0;
  assign flag_carry = 1'b0;
`endif

endmodule

// File: tb/tb_bus_reg_bank.sv
// tb_bus_reg_bank
//   Directed scenarios with literal expectations followed by randomized
//   commands, all checked every cycle against a behavioural model of the bank.
module tb_bus_reg_bank;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int MODV   = 1 << WIDTH;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, OUT = 3'd2, INC = 3'd3,
                         DEC = 3'd4, CLR = 3'd5, MOV = 3'd6;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] mon_addr;
  logic [WIDTH-1:0]  mon_value;
  logic              flag_zero;
  logic              flag_carry;

  bus_reg_bank_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_if ();

  bus_reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .mon_addr  (mon_addr),
    .mon_value (mon_value),
    .flag_zero (flag_zero),
    .flag_carry(flag_carry)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: register contents, remaining busy cycles, pending move.
  int m_regs [DEPTH];
  int m_busy;
  int m_mov_dst;
  int m_mov_val;
  bit m_mov_ok;
  int m_bus_out;
  bit m_oe;
  bit m_zero;
  bit m_carry;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_write(input int a, input int v, input bit c);
    m_regs[a] = v;
    m_zero    = (v == 0);
    m_carry   = c;
  endtask

  // Advance the model by one rising edge using the inputs the DUT samples there.
  task automatic model_step();
    int a, s, v;
    bit ok;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = 0;
      m_busy = 0; m_oe = 0; m_bus_out = 0; m_zero = 0; m_carry = 0;
      m_mov_ok = 0; m_mov_dst = 0; m_mov_val = 0;
    end else begin
      m_oe = 0;
      if (m_busy == 2) begin
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_busy = 0;
        if (m_mov_ok) m_write(m_mov_dst, m_mov_val, 1'b0);
      end else if (bus_if.cmd_valid) begin
        a  = int'(bus_if.cmd_addr);
        s  = int'(bus_if.cmd_src);
        ok = (a < DEPTH);
        v  = ok ? m_regs[a] : 0;
        case (bus_if.cmd_op)
          LOAD: if (ok) m_write(a, int'(bus_if.bus_in), 1'b0);
          OUT:  if (ok) begin m_bus_out = v; m_oe = 1; end
          INC:  if (ok) m_write(a, (v + 1) % MODV, v == MODV - 1);
          DEC:  if (ok) m_write(a, (v + MODV - 1) % MODV, v == 0);
          CLR:  if (ok) m_write(a, 0, 1'b0);
          MOV: begin
            m_busy    = 2;
            m_mov_dst = a;
            m_mov_ok  = ok && (s < DEPTH);
            m_mov_val = m_mov_ok ? m_regs[s] : 0;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_cmd(input bit valid, input logic [2:0] op, input int addr,
                         input int src, input int bin);
    bus_if.cmd_valid = valid;
    bus_if.cmd_op    = op;
    bus_if.cmd_addr  = ADDR_W'(addr);
    bus_if.cmd_src   = ADDR_W'(src);
    bus_if.bus_in    = WIDTH'(bin);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", 32'(bus_if.cmd_ready), 32'(m_busy == 0));
      check("bus_oe", 32'(bus_if.bus_oe), 32'(m_oe));
      check("bus_out", 32'(bus_if.bus_out), 32'(m_bus_out));
      check("mon_value", 32'(mon_value), (int'(mon_addr) < DEPTH) ? 32'(m_regs[mon_addr]) : 32'd0);
`ifdef BANK_FLAGS_EN
      check("flag_zero", 32'(flag_zero), 32'(m_zero));
      check("flag_carry", 32'(flag_carry), 32'(m_carry));
`else
      check("flag_zero", 32'(flag_zero), 32'd0);
      check("flag_carry", 32'(flag_carry), 32'd0);
`endif
    end
  end

  initial begin
    rst = 1'b1;
    mon_addr = '0;
    set_cmd(1'b0, NOP, 0, 0, 0);
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("rst_oe", 32'(bus_if.bus_oe), 32'd0);
    check("rst_bus_out", 32'(bus_if.bus_out), 32'd0);
    rst = 1'b0;

    // LOAD then read back through the monitor.
    set_cmd(1'b1, LOAD, 1, 0, 8'h3C); mon_addr = 2'd1;
    tick();
    set_cmd(1'b0, NOP, 0, 0, 0);
    @(negedge clk);
    check("t1_mon", 32'(mon_value), 32'h3C);
`ifdef BANK_FLAGS_EN
    check("t1_zero", 32'(flag_zero), 32'd0);
`endif

    // INC of all-ones wraps to zero.
    set_cmd(1'b1, LOAD, 2, 0, 8'hFF); tick();
    set_cmd(1'b1, INC, 2, 0, 0); tick();
    set_cmd(1'b0, NOP, 0, 0, 0); mon_addr = 2'd2;
    @(negedge clk);
    check("t2_mon", 32'(mon_value), 32'h00);
`ifdef BANK_FLAGS_EN
    check("t2_zero", 32'(flag_zero), 32'd1);
    check("t2_carry", 32'(flag_carry), 32'd1);
`endif

    // OUT drives the bus for exactly one cycle.
    set_cmd(1'b1, OUT, 1, 0, 0); tick();
    set_cmd(1'b0, NOP, 0, 0, 0);
    @(negedge clk);
    check("t3_bus_out", 32'(bus_if.bus_out), 32'h3C);
    check("t3_oe", 32'(bus_if.bus_oe), 32'd1);
    tick();
    @(negedge clk);
    check("t3_oe_drop", 32'(bus_if.bus_oe), 32'd0);
    check("t3_bus_hold", 32'(bus_if.bus_out), 32'h3C);

    // MOV with the next command held during the busy window.
    set_cmd(1'b1, MOV, 3, 1, 0); tick();
    set_cmd(1'b1, LOAD, 0, 0, 8'h11); mon_addr = 2'd3;
    @(negedge clk);
    check("t4_busy1", 32'(bus_if.cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    check("t4_busy2", 32'(bus_if.cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    check("t4_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("t4_reg3", 32'(mon_value), 32'h3C);
    mon_addr = 2'd0;
    #1;
    check("t4_held_not_yet", 32'(mon_value), 32'h00);
    tick();
    set_cmd(1'b0, NOP, 0, 0, 0);
    @(negedge clk);
    check("t4_held_load", 32'(mon_value), 32'h11);

    // DEC of zero borrows; CLR clears carry and sets zero.
    set_cmd(1'b1, CLR, 0, 0, 0); tick();
    set_cmd(1'b1, DEC, 0, 0, 0); tick();
    set_cmd(1'b0, NOP, 0, 0, 0);
    @(negedge clk);
    check("t5_dec", 32'(mon_value), 32'hFF);
`ifdef BANK_FLAGS_EN
    check("t5_borrow", 32'(flag_carry), 32'd1);
`endif
    set_cmd(1'b1, CLR, 0, 0, 0); tick();
    set_cmd(1'b0, NOP, 0, 0, 0);
    @(negedge clk);
    check("t5_clr", 32'(mon_value), 32'h00);
`ifdef BANK_FLAGS_EN
    check("t5_zero", 32'(flag_zero), 32'd1);
    check("t5_carry_clr", 32'(flag_carry), 32'd0);
`endif

    // Reset during MOV_RD aborts the move.
    set_cmd(1'b1, MOV, 2, 1, 0); tick();
    set_cmd(1'b0, NOP, 0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check("t6_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("t6_oe", 32'(bus_if.bus_oe), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      mon_addr = ADDR_W'(a);
      tick(); tick();
      @(negedge clk);
      check($sformatf("t6_reg%0d", a), 32'(mon_value), 32'd0);
    end

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      int bin;
      bin = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00)
                                        : int'($urandom_range(0, 255));
      set_cmd($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), bin);
      mon_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    set_cmd(1'b0, NOP, 0, 0, 0);
    tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
